// File: rtl/ndp_feeder.sv
// ndp_feeder: buffers k-slices of A columns / B rows, then streams them into an
// NDP unit (reset pulse, one slice per cycle, end-of-operands flag) and holds
// the unit's result until a consumer takes it.
//
// state  | meaning
// IDLE   | accepting slice writes, waiting for start
// CLEAR  | one-cycle reset pulse to the NDP unit
// FEED   | streaming buffered slices, one per cycle
// FLAG   | one-cycle end-of-operands flag
// WAIT   | waiting for calc_done_flag from the NDP unit
// RESULT | result held until res_ready handshake
module ndp_feeder #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 1,
  parameter int K_MAX      = 8,
  localparam int A_W = SYS_HEIGHT * ARR_HEIGHT * WIDTH,
  localparam int B_W = SYS_WIDTH * ARR_WIDTH * WIDTH,
  localparam int C_W = A_W * SYS_WIDTH * ARR_WIDTH,
  localparam int CW  = $clog2(K_MAX + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [A_W-1:0] wr_a,
  input  logic [B_W-1:0] wr_b,
  output logic           wr_ready,
  output logic [CW-1:0]  k_count,
  input  logic           start,
  output logic           busy,
  output logic           ndp_reset,
  output logic [A_W-1:0] in_a,
  output logic [B_W-1:0] in_b,
  output logic           in_done_flag,
  input  logic           calc_done_flag,
  input  logic [C_W-1:0] out_c,
  output logic           res_valid,
  output logic [C_W-1:0] res_data,
  input  logic           res_ready
);

  // Buffer index width; depth rounded to a power of two so the slice index
  // never selects outside the array.
  localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLAG, S_WAIT, S_RESULT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  k_count_q, k_count_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [A_W-1:0] in_a_q, in_a_d;
  logic [B_W-1:0] in_b_q, in_b_d;
  logic           in_done_q, in_done_d;
  logic           res_valid_q, res_valid_d;
  logic [C_W-1:0] res_data_q, res_data_d;
  logic [CW-1:0]  k_next;
  logic           wr_acc;

  logic [A_W-1:0] buf_a [DEPTH];
  logic [B_W-1:0] buf_b [DEPTH];

  assign wr_ready     = (state_q == S_IDLE) && (k_count_q < CW'(K_MAX));
  assign wr_acc       = wr_en && wr_ready;
  assign k_count      = k_count_q;
  assign busy         = (state_q != S_IDLE);
  assign ndp_reset    = reset || (state_q == S_CLEAR);
  assign in_a         = in_a_q;
  assign in_b         = in_b_q;
  assign in_done_flag = in_done_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;

  // Slice storage; writes land at the current count, only while in IDLE.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      buf_a[k_count_q[AW-1:0]] <= wr_a;
      buf_b[k_count_q[AW-1:0]] <= wr_b;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they appear
  // registered in the same cycle the FSM enters the matching state.
  always_comb begin
    state_d    = state_q;
    k_count_d  = k_count_q;
    idx_d      = idx_q;
    res_data_d = res_data_q;
    k_next     = k_count_q + CW'(wr_acc);
    case (state_q)
      S_IDLE: begin
        k_count_d = k_next;
        if (start && (k_next != '0)) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (idx_q == k_count_q - CW'(1)) state_d = S_FLAG;
        else                             idx_d   = idx_q + CW'(1);
      end
      S_FLAG: state_d = S_WAIT;
      S_WAIT: begin
        if (calc_done_flag) begin
          res_data_d = out_c;
          state_d    = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          k_count_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_a_d      = (state_d == S_FEED) ? buf_a[idx_d[AW-1:0]] : '0;
    in_b_d      = (state_d == S_FEED) ? buf_b[idx_d[AW-1:0]] : '0;
    in_done_d   = (state_d == S_FLAG);
    res_valid_d = (state_d == S_RESULT);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_count_q   <= '0;
      idx_q       <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      in_done_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_count_q   <= k_count_d;
      idx_q       <= idx_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      in_done_q   <= in_done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_ndp_feeder.sv
// tb_ndp_feeder: drives random slice loads and jobs into ndp_feeder and checks
// the stream against a queue-based model of the expected operand sequence.
module tb_ndp_feeder;
  localparam int WIDTH = 16, ARR_HEIGHT = 4, ARR_WIDTH = 4;
  localparam int SYS_HEIGHT = 1, SYS_WIDTH = 1, K_MAX = 8;
  localparam int A_W = SYS_HEIGHT * ARR_HEIGHT * WIDTH;
  localparam int B_W = SYS_WIDTH * ARR_WIDTH * WIDTH;
  localparam int C_W = A_W * SYS_WIDTH * ARR_WIDTH;
  localparam int CW  = $clog2(K_MAX + 1);

  logic           clk = 1'b0;
  logic           reset, wr_en, start, calc_done_flag, res_ready;
  logic [A_W-1:0] wr_a, in_a;
  logic [B_W-1:0] wr_b, in_b;
  logic           wr_ready, busy, ndp_reset, in_done_flag, res_valid;
  logic [CW-1:0]  k_count;
  logic [C_W-1:0] out_c, res_data;

  int total = 0;
  int bad   = 0;

  logic [A_W-1:0] ma[$];
  logic [B_W-1:0] mb[$];

  ndp_feeder #(
    .WIDTH(WIDTH), .ARR_HEIGHT(ARR_HEIGHT), .ARR_WIDTH(ARR_WIDTH),
    .SYS_HEIGHT(SYS_HEIGHT), .SYS_WIDTH(SYS_WIDTH), .K_MAX(K_MAX)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
    .wr_ready(wr_ready), .k_count(k_count), .start(start), .busy(busy),
    .ndp_reset(ndp_reset), .in_a(in_a), .in_b(in_b),
    .in_done_flag(in_done_flag), .calc_done_flag(calc_done_flag),
    .out_c(out_c), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [C_W-1:0] obs, input logic [C_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [C_W-1:0] rand_c();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One write attempt; the model accepts it only while fewer than K_MAX are held.
  task automatic write_slice(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic exp_acc;
    exp_acc = (ma.size() < K_MAX);
    chk("wr_ready", C_W'(wr_ready), C_W'(exp_acc));
    wr_en = 1'b1; wr_a = a; wr_b = b;
    tick();
    wr_en = 1'b0;
    if (exp_acc) begin
      ma.push_back(a);
      mb.push_back(b);
    end
    chk("k_count_wr", C_W'(k_count), C_W'(ma.size()));
  endtask

  // Full job: start, clear pulse, slice stream, flag, wait, result handshake.
  task automatic run_job(input int wait_cyc, input int stall, input bit with_wr, input bit spur_feed);
    int k;
    logic [C_W-1:0] c;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    if (with_wr) begin
      a = rand64(); b = rand64();
      wr_en = 1'b1; wr_a = a; wr_b = b;
      if (ma.size() < K_MAX) begin
        ma.push_back(a);
        mb.push_back(b);
      end
    end
    start = 1'b1;
    tick();
    k = ma.size();
    chk("clear_ndp_reset", C_W'(ndp_reset), 1);
    chk("clear_busy", C_W'(busy), 1);
    chk("clear_in_a", C_W'(in_a), 0);
    chk("clear_wr_ready", C_W'(wr_ready), 0);
    wr_en = 1'b1; wr_a = rand64(); wr_b = rand64();
    for (int i = 0; i < k; i++) begin
      tick();
      wr_en = 1'b0; start = 1'b0;
      chk("feed_in_a", C_W'(in_a), C_W'(ma[i]));
      chk("feed_in_b", C_W'(in_b), C_W'(mb[i]));
      chk("feed_ndp_reset", C_W'(ndp_reset), 0);
      chk("feed_done_flag", C_W'(in_done_flag), 0);
      calc_done_flag = spur_feed && (i == 0);
    end
    tick();
    calc_done_flag = 1'b0;
    chk("flag_done", C_W'(in_done_flag), 1);
    chk("flag_in_a", C_W'(in_a), 0);
    chk("flag_in_b", C_W'(in_b), 0);
    chk("flag_k_count", C_W'(k_count), C_W'(k));
    for (int w = 0; w < wait_cyc; w++) begin
      tick();
      chk("wait_done_flag", C_W'(in_done_flag), 0);
      chk("wait_res_valid", C_W'(res_valid), 0);
      chk("wait_in_a", C_W'(in_a), 0);
      chk("wait_busy", C_W'(busy), 1);
    end
    c = rand_c();
    out_c = c; calc_done_flag = 1'b1;
    tick();
    calc_done_flag = 1'b0; out_c = rand_c();
    chk("res_valid", C_W'(res_valid), 1);
    chk("res_data", res_data, c);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_res_valid", C_W'(res_valid), 1);
      chk("stall_res_data", res_data, c);
      chk("stall_k_count", C_W'(k_count), C_W'(k));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("done_res_valid", C_W'(res_valid), 0);
    chk("done_busy", C_W'(busy), 0);
    chk("done_k_count", C_W'(k_count), 0);
    chk("done_wr_ready", C_W'(wr_ready), 1);
    ma.delete();
    mb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; calc_done_flag = 1'b0;
    res_ready = 1'b0; wr_a = '0; wr_b = '0; out_c = '0;
    tick(); tick();
    chk("rst_ndp_reset", C_W'(ndp_reset), 1);
    chk("rst_busy", C_W'(busy), 0);
    chk("rst_in_a", C_W'(in_a), 0);
    chk("rst_k_count", C_W'(k_count), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_valid", C_W'(res_valid), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_wr_ready", C_W'(wr_ready), 1);
    chk("post_rst_ndp_reset", C_W'(ndp_reset), 0);

    // Five known slices, long wait, stalled consumer.
    for (int k = 0; k < 5; k++) write_slice(64'h0001_0002_0003_0004 + 64'(k), rand64());
    run_job(12, 3, 1'b0, 1'b0);

    // Overfill: ninth write dropped, FEED runs K_MAX slices.
    for (int k = 0; k < 9; k++) write_slice(rand64(), rand64());
    run_job(3, 1, 1'b0, 1'b0);

    // Start with nothing buffered is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_busy", C_W'(busy), 0);
    chk("empty_start_ndp_reset", C_W'(ndp_reset), 0);
    // Start together with the first write gives a one-slice job.
    run_job(2, 0, 1'b1, 1'b0);

    // Spurious calc_done in IDLE.
    calc_done_flag = 1'b1; out_c = rand_c();
    tick();
    calc_done_flag = 1'b0;
    chk("idle_spur_res_valid", C_W'(res_valid), 0);
    chk("idle_spur_busy", C_W'(busy), 0);

    // Reset on the third FEED cycle aborts the job.
    for (int k = 0; k < 4; k++) write_slice(rand64(), rand64());
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_feed3_in_a", C_W'(in_a), C_W'(ma[2]));
    reset = 1'b1;
    tick();
    chk("abort_busy", C_W'(busy), 0);
    chk("abort_in_a", C_W'(in_a), 0);
    chk("abort_ndp_reset", C_W'(ndp_reset), 1);
    chk("abort_done_flag", C_W'(in_done_flag), 0);
    chk("abort_res_valid", C_W'(res_valid), 0);
    tick();
    chk("abort_ndp_reset_hold", C_W'(ndp_reset), 1);
    reset = 1'b0;
    ma.delete();
    mb.delete();
    tick();
    chk("abort_wr_ready", C_W'(wr_ready), 1);
    chk("abort_k_count", C_W'(k_count), 0);
    chk("abort_res_valid2", C_W'(res_valid), 0);
    for (int k = 0; k < 2; k++) write_slice(rand64(), rand64());
    run_job(4, 1, 1'b0, 1'b0);

    // Randomized jobs, one with a spurious calc_done during FEED.
    for (int j = 0; j < 8; j++) begin
      int kk;
      kk = int'($urandom_range(1, K_MAX));
      for (int k = 0; k < kk; k++) write_slice(rand64(), rand64());
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0, j == 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ndp_feeder.md
NDP_FEEDER -- requirements
Module: ndp_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 16, element width
- ARR_HEIGHT, 4, PE rows per array
- ARR_WIDTH, 4, PE columns per array
- SYS_HEIGHT, 1, arrays vertically
- SYS_WIDTH, 1, arrays horizontally
- K_MAX, 8, max inner dimension (slices buffered)
REQ-002 Derived widths: A_W = SYS_HEIGHT*ARR_HEIGHT*WIDTH; B_W = SYS_WIDTH*ARR_WIDTH*WIDTH; C_W = A_W*SYS_WIDTH*ARR_WIDTH; CW = clog2(K_MAX+1).
REQ-003 Ports (name direction width meaning), one per line:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  load one k-slice
- wr_a  in  A_W  column of A for slice k
- wr_b  in  B_W  row of B for slice k
- wr_ready  out  1  slice write accepted when high
- k_count  out  CW  slices currently buffered
- start  in  1  begin a matmul on buffered slices
- busy  out  1  high in any state except IDLE
- ndp_reset  out  1  reset to NDP_unit
- in_a  out  A_W  to NDP_unit in_a
- in_b  out  B_W  to NDP_unit in_b
- in_done_flag  out  1  to NDP_unit, end of operands
- calc_done_flag  in  1  from NDP_unit
- out_c  in  C_W  from NDP_unit
- res_valid  out  1  result held
- res_data  out  C_W  captured result
- res_ready  in  1  consumer accepts result

Function
REQ-004 FSM states: IDLE, CLEAR, FEED, FLAG, WAIT, RESULT; one state per cycle except where stated.
REQ-005 IDLE: wr_ready = (k_count < K_MAX); wr_en && wr_ready stores wr_a/wr_b at index k_count, k_count += 1; wr_ready = 0 in all other states.
REQ-006 Write at k_count == K_MAX is dropped; buffer and k_count unchanged.
REQ-007 IDLE with start=1 and post-write count > 0 -> CLEAR; a same-cycle accepted write counts; start with count 0 is ignored.
REQ-008 CLEAR: ndp_reset = 1 for exactly one cycle, in_a/in_b = 0 -> FEED with idx = 0.
REQ-009 FEED: in_a = bufA[idx], in_b = bufB[idx], one slice per cycle, idx += 1; after slice k_count-1 -> FLAG; FEED lasts exactly k_count cycles.
REQ-010 FLAG: in_done_flag = 1 for exactly one cycle, in_a/in_b = 0 -> WAIT.
REQ-011 WAIT: hold in_a/in_b = 0; on calc_done_flag = 1 capture out_c into res_data that cycle -> RESULT; calc_done_flag in any other state is ignored.
REQ-012 RESULT: res_valid = 1, res_data stable; res_valid && res_ready -> IDLE with k_count = 0 (buffer contents need not clear).
REQ-013 in_a, in_b, in_done_flag, res_valid are state-decoded registered values; in_a/in_b = 0 outside FEED.
REQ-014 ndp_reset = reset OR (state == CLEAR).
REQ-015 start, wr_en outside IDLE are ignored.
REQ-016 Timing: start sampled at edge T -> ndp_reset high T..T+1; slice 0 on in_a/in_b T+1..T+2; in_done_flag high at T+1+k_count.

Reset
REQ-017 Reset is synchronous and active-high: state IDLE, k_count 0, idx 0, res_data 0, and in_a, in_b, in_done_flag, res_valid, busy = 0; wr_ready = 1 the cycle after reset releases.
REQ-018 Reset in any state, including mid-FEED or WAIT, aborts the operation the next edge with no result produced; ndp_reset stays high while reset is high.

Verification
REQ-019 Load 5 slices (wr_a = 0x0001_0002_0003_0004 + k), start -> ndp_reset one cycle, slices 0..4 on consecutive cycles, in_done_flag one cycle later, k_count 5 until result consumed.
REQ-020 calc_done_flag after 12 cycles in WAIT with out_c = 0xA5A5..., res_ready = 0 for 3 cycles -> res_valid held 3 cycles with res_data = 0xA5A5...; handshake -> IDLE, k_count 0.
REQ-021 Write 9 slices with K_MAX = 8 -> wr_ready low after 8th, 9th dropped, FEED lasts 8 cycles.
REQ-022 start with k_count 0 -> stays IDLE, busy 0; start plus same-cycle first write -> FEED lasts 1 cycle.
REQ-023 Reset at 3rd FEED cycle -> IDLE next edge, in_a = 0, no res_valid; new 2-slice job completes correctly.
REQ-024 calc_done_flag pulsed in IDLE and FEED -> ignored, no result.
